yuv422_to_rgb_pipe: RTL and testbench

Parametrised YUV 4:2:2 to RGB converter for the camera capture path. It accepts one 32-bit beat per transfer, carrying two pixels that share chroma, and emits two RGB888 pixels with frame coordinates and frame/line markers. It generalises the fixed YUYV/full-range converter in four ways: selectable byte order, selectable full or limited (studio) range, valid/ready backpressure through the whole pipeline, and a soft frame resynchronisation input. It sits between the capture FIFO and the display/frame-buffer writer.

---
 rtl/yuv422_to_rgb_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_yuv422_to_rgb_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_to_rgb_pipe.sv
// yuv422_to_rgb_pipe
// Three-stage YUV 4:2:2 to RGB888 converter. Each accepted 32-bit beat carries
// two luma samples that share one chroma pair; the block outputs two RGB pixels
// tagged with frame coordinates and frame/line markers.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fmt_sel[1:0]        byte order: 0 YUYV, 1 UYVY, 2 YVYU, 3 VYUY
//   range_sel           0 BT.601 full range, 1 BT.601 limited range
//   sync_clr            restart the pixel counters at (0,0)
//   in_valid/in_ready   input handshake, in_data[31:0] two-pixel beat
//   out_valid/out_ready output handshake
//   r0/g0/b0_out        first pixel of the pair, r1/g1/b1_out second pixel
//   pixel_x, pixel_y    coordinate of the first pixel of the pair
//   out_sof, out_eol    pair at (0,0) / pair at the last x of a line
module yuv422_to_rgb_pipe #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 466,
  parameter int COORD_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         fmt_sel,
  input  logic               range_sel,
  input  logic               sync_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         r0_out,
  output logic [7:0]         g0_out,
  output logic [7:0]         b0_out,
  output logic [7:0]         r1_out,
  output logic [7:0]         g1_out,
  output logic [7:0]         b1_out,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               out_sof,
  output logic               out_eol
);

  localparam int DATA_W = 10;   // offset-corrected sample width
  localparam int COEF_W = 11;
  localparam int PROD_W = 20;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 2);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_STEP = COORD_W'(2);
  localparam logic [COORD_W-1:0] Y_STEP = COORD_W'(1);

  localparam logic signed [DATA_W-1:0] OFS_C   = 10'sd128;
  localparam logic signed [DATA_W-1:0] OFS_Y_L = 10'sd16;
  localparam logic signed [DATA_W-1:0] OFS_Y_F = 10'sd0;

  localparam logic signed [COEF_W-1:0] KY_F  = 11'sd256, KY_L  = 11'sd298;
  localparam logic signed [COEF_W-1:0] KRV_F = 11'sd359, KRV_L = 11'sd409;
  localparam logic signed [COEF_W-1:0] KGU_F = 11'sd88,  KGU_L = 11'sd100;
  localparam logic signed [COEF_W-1:0] KGV_F = 11'sd183, KGV_L = 11'sd208;
  localparam logic signed [COEF_W-1:0] KBU_F = 11'sd454, KBU_L = 11'sd516;

  function automatic logic signed [DATA_W-1:0] offset(input logic [7:0] b,
                                                      input logic signed [DATA_W-1:0] ofs);
    return $signed({2'b00, b}) - ofs;
  endfunction

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [COEF_W-1:0] k);
    logic signed [PROD_W-1:0] ax, kx;
    ax = PROD_W'(a);
    kx = PROD_W'(k);
    return ax * kx;
  endfunction

  // Round to nearest, then saturate the 8.8 fixed-point result to 0..255.
  function automatic logic [7:0] clamp_u8(input logic signed [PROD_W-1:0] v);
    logic signed [PROD_W-1:0] s;
    s = v + 20'sd128;
    if (s < 0)
      return 8'd0;
    else if (s > 20'sd65535)
      return 8'hFF;
    else
      return s[15:8];
  endfunction

  logic en, accept;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Coordinate tagging: sync_clr retags the current beat as (0,0).
  logic [COORD_W-1:0] cnt_x, cnt_y, tag_x, tag_y;
  logic               tag_zero, x_last, y_last;
  logic [1:0]         mode_fmt, eff_fmt;
  logic               mode_rng, eff_rng;

  always_comb begin
    tag_x    = sync_clr ? '0 : cnt_x;
    tag_y    = sync_clr ? '0 : cnt_y;
    tag_zero = (tag_x == '0) && (tag_y == '0);
    x_last   = (tag_x == X_LAST);
    y_last   = (tag_y == Y_LAST);
    // The first beat of a frame uses the live mode inputs it latches.
    eff_fmt  = tag_zero ? fmt_sel   : mode_fmt;
    eff_rng  = tag_zero ? range_sel : mode_rng;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x    <= '0;
      cnt_y    <= '0;
      mode_fmt <= 2'd0;
      mode_rng <= 1'b0;
    end else begin
      if (accept) begin
        if (x_last) begin
          cnt_x <= '0;
          cnt_y <= y_last ? '0 : tag_y + Y_STEP;
        end else begin
          cnt_x <= tag_x + X_STEP;
          cnt_y <= tag_y;
        end
        if (tag_zero) begin
          mode_fmt <= fmt_sel;
          mode_rng <= range_sel;
        end
      end else if (sync_clr) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end
    end
  end

  logic [7:0] y0_b, y1_b, u_b, v_b;

  always_comb begin
    y0_b = in_data[31:24];
    u_b  = in_data[23:16];
    y1_b = in_data[15:8];
    v_b  = in_data[7:0];
    case (eff_fmt)
      2'd1: begin u_b = in_data[31:24]; y0_b = in_data[23:16]; v_b = in_data[15:8];  y1_b = in_data[7:0]; end
      2'd2: begin y0_b = in_data[31:24]; v_b = in_data[23:16]; y1_b = in_data[15:8]; u_b = in_data[7:0];  end
      2'd3: begin v_b = in_data[31:24]; y0_b = in_data[23:16]; u_b = in_data[15:8];  y1_b = in_data[7:0]; end
      default: ;
    endcase
  end

  // ---- S1: unpack and offset ----
  logic                      vld_p0, lim_p0, sof_p0, eol_p0;
  logic signed [DATA_W-1:0]  y0_p0, y1_p0, cb_p0, cr_p0;
  logic [COORD_W-1:0]        x_p0, yy_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_p0 <= 1'b0;
    else if (en) vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      y0_p0  <= offset(y0_b, eff_rng ? OFS_Y_L : OFS_Y_F);
      y1_p0  <= offset(y1_b, eff_rng ? OFS_Y_L : OFS_Y_F);
      cb_p0  <= offset(u_b, OFS_C);
      cr_p0  <= offset(v_b, OFS_C);
      lim_p0 <= eff_rng;
      x_p0   <= tag_x;
      yy_p0  <= tag_y;
      sof_p0 <= tag_zero;
      eol_p0 <= x_last;
    end
  end

  // ---- S2: products ----
  logic                      vld_p1, sof_p1, eol_p1;
  logic signed [PROD_W-1:0]  yc0_p1, yc1_p1, rv_p1, gu_p1, gv_p1, bu_p1;
  logic [COORD_W-1:0]        x_p1, yy_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      yc0_p1 <= mul(y0_p0, lim_p0 ? KY_L  : KY_F);
      yc1_p1 <= mul(y1_p0, lim_p0 ? KY_L  : KY_F);
      rv_p1  <= mul(cr_p0, lim_p0 ? KRV_L : KRV_F);
      gu_p1  <= mul(cb_p0, lim_p0 ? KGU_L : KGU_F);
      gv_p1  <= mul(cr_p0, lim_p0 ? KGV_L : KGV_F);
      bu_p1  <= mul(cb_p0, lim_p0 ? KBU_L : KBU_F);
      x_p1   <= x_p0;
      yy_p1  <= yy_p0;
      sof_p1 <= sof_p0;
      eol_p1 <= eol_p0;
    end
  end

  // ---- S3: sums, clamp and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r0_out    <= 8'd0;
      g0_out    <= 8'd0;
      b0_out    <= 8'd0;
      r1_out    <= 8'd0;
      g1_out    <= 8'd0;
      b1_out    <= 8'd0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p1;
      r0_out    <= clamp_u8(yc0_p1 + rv_p1);
      g0_out    <= clamp_u8(yc0_p1 - gu_p1 - gv_p1);
      b0_out    <= clamp_u8(yc0_p1 + bu_p1);
      r1_out    <= clamp_u8(yc1_p1 + rv_p1);
      g1_out    <= clamp_u8(yc1_p1 - gu_p1 - gv_p1);
      b1_out    <= clamp_u8(yc1_p1 + bu_p1);
      pixel_x   <= x_p1;
      pixel_y   <= yy_p1;
      out_sof   <= sof_p1;
      out_eol   <= eol_p1;
    end
  end

endmodule

// File: tb/tb_yuv422_to_rgb_pipe.sv
module tb_yuv422_to_rgb_pipe;
  localparam int W  = 8;
  localparam int H  = 3;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    fmt_sel = 2'd0;
  logic          range_sel = 1'b0;
  logic          sync_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    r0_out, g0_out, b0_out, r1_out, g1_out, b1_out;
  logic [CW-1:0] pixel_x, pixel_y;
  logic          out_sof, out_eol;

  yuv422_to_rgb_pipe #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fmt_sel(fmt_sel), .range_sel(range_sel),
    .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .r0_out(r0_out), .g0_out(g0_out), .b0_out(b0_out),
    .r1_out(r1_out), .g1_out(g1_out), .b1_out(b1_out),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] rgb;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
    int          t;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          en_cnt = 0;
  int          mx = 0, my = 0;
  logic [1:0]  m_fmt = 2'd0;
  bit          m_rng = 1'b0;
  bit          stall_prev = 1'b0;
  logic [70:0] snap;
  bit          rnd_done;

  // Reference model: BT.601 integer conversion straight from the formulas.
  function automatic int clampi(int s);
    int r;
    r = s + 128;
    if (r < 0) return 0;
    if (r > 65535) return 255;
    return r / 256;
  endfunction

  function automatic logic [23:0] pix(int y, int cb, int cr, bit lim);
    int yc, r, g, b;
    if (!lim) begin
      yc = y * 256;
      r = yc + 359 * cr; g = yc - 88 * cb - 183 * cr; b = yc + 454 * cb;
    end else begin
      yc = (y - 16) * 298;
      r = yc + 409 * cr; g = yc - 100 * cb - 208 * cr; b = yc + 516 * cb;
    end
    return {8'(clampi(r)), 8'(clampi(g)), 8'(clampi(b))};
  endfunction

  function automatic logic [47:0] ref_pair(logic [31:0] d, logic [1:0] f, bit lim);
    int b3, b2, b1, b0, y0, y1, u, v;
    b3 = int'(d[31:24]); b2 = int'(d[23:16]); b1 = int'(d[15:8]); b0 = int'(d[7:0]);
    case (f)
      2'd0: begin y0 = b3; u = b2; y1 = b1; v = b0; end
      2'd1: begin u = b3; y0 = b2; v = b1; y1 = b0; end
      2'd2: begin y0 = b3; v = b2; y1 = b1; u = b0; end
      default: begin v = b3; y0 = b2; u = b1; y1 = b0; end
    endcase
    return {pix(y0, u - 128, v - 128, lim), pix(y1, u - 128, v - 128, lim)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else if (in_ready) en_cnt <= en_cnt + 1;
  end

  // Model bookkeeping for one accepted beat.
  task automatic push(logic [31:0] d, logic [1:0] f, bit lim, bit sclr, bit gold, logic [47:0] grgb);
    exp_t e;
    int tx, ty;
    tx = sclr ? 0 : mx;
    ty = sclr ? 0 : my;
    if (tx == 0 && ty == 0) begin m_fmt = f; m_rng = lim; end
    e.rgb = gold ? grgb : ref_pair(d, m_fmt, m_rng);
    e.x = tx; e.y = ty; e.sof = (tx == 0 && ty == 0); e.eol = (tx == W - 2); e.t = en_cnt;
    sbq.push_back(e);
    if (tx == W - 2) begin
      mx = 0;
      my = (ty == H - 1) ? 0 : ty + 1;
    end else begin
      mx = tx + 2;
      my = ty;
    end
  endtask

  task automatic send(logic [31:0] d, logic [1:0] f, bit lim, bit sclr, bit gold, logic [47:0] grgb);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = d; fmt_sel = f; range_sel = lim; sync_clr = sclr;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push(d, f, lim, sclr, gold, grgb);
        break;
      end
      guard++;
      if (guard > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: beat %h never accepted", d);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; sync_clr = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pairs outstanding, expected 0", sbq.size());
    end
    #1;
  endtask

  // Monitor: pops one expectation per output handshake, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 128'(snap),
            128'({out_valid, r0_out, g0_out, b0_out, r1_out, g1_out, b1_out,
                  pixel_x, pixel_y, out_sof, out_eol}));
      if (out_valid && !out_ready) chk("in_ready_stall", 128'(in_ready), 128'(0));
      stall_prev = out_valid && !out_ready;
      snap = {out_valid, r0_out, g0_out, b0_out, r1_out, g1_out, b1_out,
              pixel_x, pixel_y, out_sof, out_eol};
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got pair at (%0d,%0d), expected none", pixel_x, pixel_y);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rgb", 128'({r0_out, g0_out, b0_out, r1_out, g1_out, b1_out}), 128'(e.rgb));
          chk("pixel_x", 128'(pixel_x), 128'(e.x));
          chk("pixel_y", 128'(pixel_y), 128'(e.y));
          chk("out_sof", 128'(out_sof), 128'(e.sof));
          chk("out_eol", 128'(out_eol), 128'(e.eol));
          chk("latency", 128'(en_cnt), 128'(e.t + 3));
        end
      end
    end
  end

  task automatic check_reset_state(string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_rgb"}, 128'({r0_out, g0_out, b0_out, r1_out, g1_out, b1_out}), 128'(0));
    chk({tag, "_xy"}, 128'({pixel_x, pixel_y}), 128'(0));
    chk({tag, "_flags"}, 128'({out_sof, out_eol}), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    bit done_sync;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Directed values from hand calculation.
    send(32'h80808080, 2'd0, 1'b0, 1'b1, 1'b1, {6{8'd128}});
    send(32'hFF8000FF, 2'd0, 1'b0, 1'b1, 1'b1, {8'd255, 8'd164, 8'd255, 8'd178, 8'd0, 8'd0});
    send(32'h80108010, 2'd1, 1'b1, 1'b1, 1'b1, 48'd0);
    send(32'h80EB80EB, 2'd1, 1'b1, 1'b0, 1'b1, {6{8'd255}});
    send(32'h00800000, 2'd0, 1'b0, 1'b1, 1'b1, {8'd0, 8'd92, 8'd0, 8'd0, 8'd92, 8'd0});
    drain();

    // Backpressure: 8 back-to-back beats, out_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 48'd0);
      end
      begin
        idle(4);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain();

    // 1.5 frames from a clean frame start, then sync_clr on the beat at (4,1).
    send($urandom, 2'd2, 1'b0, 1'b1, 1'b0, 48'd0);
    for (int i = 0; i < 17; i++)
      send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 48'd0);
    done_sync = 1'b0;
    for (int i = 0; i < 20 && !done_sync; i++) begin
      if (mx == 4 && my == 1) begin
        send($urandom, 2'd3, 1'b1, 1'b1, 1'b0, 48'd0);
        done_sync = 1'b1;
      end else begin
        send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 48'd0);
      end
    end
    chk("sync_reached", 128'(done_sync), 128'(1));
    send($urandom, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    send($urandom, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    drain();

    // Randomised traffic with random backpressure and occasional resync.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0), 1'b0, 48'd0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-frame reset: pipeline contents discarded, counter back to (0,0).
    send($urandom, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    send($urandom, 2'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    rst_n = 1'b0;
    sbq.delete();
    mx = 0; my = 0; m_fmt = 2'd0; m_rng = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send($urandom, 2'd1, 1'b1, 1'b0, 1'b0, 48'd0);
    send($urandom, 2'd3, 1'b0, 1'b0, 1'b0, 48'd0);
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
